// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction-fetch initiator. Generates the fetch PC, drives the synchronous
//   instruction-memory read port (1-cycle registered read data, held while
//   stalled), pairs each returned word with its PC and presents it to decode.
//   Handles decode backpressure, redirects (wrong-path kill), misaligned
//   redirect targets and counts instructions accepted by decode.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_addr/imem_stall: memory request address / hold-data request
//   imem_data           : memory read data for the previously issued address
//   id_stall            : decode cannot accept this cycle
//   redirect_valid/_pc  : taken control transfer from EX and its target
//   if_instr/if_pc      : instruction and its PC to decode
//   if_valid            : if_instr/if_pc meaningful
//   if_misalign         : entry came from a misaligned redirect target
//   fetch_count         : instructions accepted by decode (wraps)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  output logic             imem_stall,
  input  logic [31:0]      imem_data,
  input  logic             id_stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             if_valid,
  output logic             if_misalign,
  output logic [CNT_W-1:0] fetch_count
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      fpc_q, fpc_d;
  logic             fvld_q, fvld_d;
  logic             fmis_q, fmis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic redir;
  logic advance;
  logic accept;

  always_comb begin
    // Redirect is ignored while reset is held so imem_addr shows RESET_PC.
    redir      = redirect_valid & rst_n;
    // An empty fetch slot (bubble) never blocks fetch; a redirect always
    // advances, even against decode backpressure.
    advance    = redir | ~id_stall | ~fvld_q;
    imem_stall = ~advance;
    imem_addr  = redir ? {redirect_pc[31:2], 2'b00} : pc_q;

    if_instr    = imem_data;
    if_pc       = fpc_q;
    // The word on the interface during a redirect cycle is wrong-path.
    if_valid    = fvld_q & ~redir;
    if_misalign = fmis_q & if_valid;
    fetch_count = cnt_q;
    accept      = if_valid & ~id_stall;

    pc_d   = pc_q;
    fpc_d  = fpc_q;
    fvld_d = fvld_q;
    fmis_d = fmis_q;
    cnt_d  = cnt_q;

    if (advance) begin
      fpc_d  = imem_addr;
      fvld_d = 1'b1;
      fmis_d = redir & (redirect_pc[1:0] != 2'b00);
      pc_d   = imem_addr + 32'd4;
    end

    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      fpc_q  <= 32'h0000_0000;
      fvld_q <= 1'b0;
      fmis_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      fvld_q <= fvld_d;
      fmis_q <= fmis_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: a synchronous memory model feeds the DUT;
// directed stimulus pushes the expected accepted-instruction stream into a
// queue, and a monitor pops and compares on every accept.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_stall;
  logic [31:0] imem_data;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_misalign;
  logic [31:0] fetch_count;

  // Second instance exercising a RESET_PC near the top of the address space.
  logic [31:0] w_imem_addr;
  logic        w_imem_stall;
  logic [31:0] w_imem_data;
  logic        w_id_stall;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_if_valid;
  logic        w_if_misalign;
  logic [31:0] w_fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   mon_cnt = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_stall(imem_stall), .imem_data(imem_data),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .if_misalign(if_misalign), .fetch_count(fetch_count)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(32)) u_dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(w_imem_addr), .imem_stall(w_imem_stall), .imem_data(w_imem_data),
    .id_stall(w_id_stall), .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .if_instr(w_if_instr), .if_pc(w_if_pc), .if_valid(w_if_valid),
    .if_misalign(w_if_misalign), .fetch_count(w_fetch_count)
  );

  assign w_id_stall       = 1'b0;
  assign w_redirect_valid = 1'b0;
  assign w_redirect_pc    = 32'h0000_0000;
  assign w_imem_data      = 32'h0000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Synchronous memory: registered read, data held while stalled.
  always @(posedge clk) begin
    if (!imem_stall) imem_data <= word(imem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc  = pc;
    e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accept by decode is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt = 0;
    end else if (if_valid && !id_stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept_pc", if_pc, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_pc", if_pc, e.pc);
        chk("acc_instr", if_instr, word(e.pc));
        chk("acc_misalign", {31'd0, if_misalign}, {31'd0, e.mis});
        chk("acc_count", fetch_count, mon_cnt);
      end
      mon_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_misalign", {31'd0, if_misalign}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_imem_stall", {31'd0, imem_stall}, 32'd0);
    chk("rst_w_imem_addr", w_imem_addr, 32'hFFFF_FFF8);

    push(32'h0, 1'b0); push(32'h4, 1'b0); push(32'h8, 1'b0); push(32'hC, 1'b0);
    push(32'h100, 1'b0); push(32'h104, 1'b0); push(32'h200, 1'b1);
    push(32'h204, 1'b0); push(32'h400, 1'b0);

    cyc(); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_imem_addr", imem_addr, 32'h0);
    chk("rel_if_valid", {31'd0, if_valid}, 32'd0);

    cyc(); @(negedge clk);                       // W1
    chk("w1_if_valid", {31'd0, if_valid}, 32'd1);
    chk("w1_imem_addr", imem_addr, 32'h4);
    chk("wrap_pc0", w_if_pc, 32'hFFFF_FFF8);

    cyc(); @(negedge clk);                       // W2
    chk("w2_imem_addr", imem_addr, 32'h8);
    chk("wrap_pc1", w_if_pc, 32'hFFFF_FFFC);

    cyc(); id_stall = 1'b1; @(negedge clk);      // W3..W5 stalled on 8
    chk("wrap_pc2", w_if_pc, 32'h0000_0000);
    chk("wrap_addr2", w_imem_addr, 32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); @(negedge clk); end
      chk("stall_imem_stall", {31'd0, imem_stall}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h8);
      chk("stall_if_instr", if_instr, word(32'h8));
      chk("stall_count", fetch_count, 32'd2);
    end

    cyc(); id_stall = 1'b0; @(negedge clk);      // W6: 8 accepted
    chk("unstall_imem_stall", {31'd0, imem_stall}, 32'd0);
    cyc(); @(negedge clk);                       // W7
    chk("w7_if_pc", if_pc, 32'hC);

    cyc(); id_stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);                              // W8: redirect over stall
    chk("redir_if_valid", {31'd0, if_valid}, 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h100);
    chk("redir_imem_stall", {31'd0, imem_stall}, 32'd0);
    chk("redir_count", fetch_count, 32'd4);

    cyc(); redirect_valid = 1'b0; id_stall = 1'b0; @(negedge clk);
    chk("tgt_if_pc", if_pc, 32'h100);
    chk("tgt_if_valid", {31'd0, if_valid}, 32'd1);
    cyc(); @(negedge clk);                       // W10: 0x104

    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h202; @(negedge clk);
    chk("mis_imem_addr", imem_addr, 32'h200);
    chk("mis_if_valid", {31'd0, if_valid}, 32'd0);
    cyc(); redirect_valid = 1'b0; @(negedge clk);
    chk("mis_if_misalign", {31'd0, if_misalign}, 32'd1);
    cyc(); @(negedge clk);
    chk("seq_if_misalign", {31'd0, if_misalign}, 32'd0);

    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300; @(negedge clk);
    chk("b2b1_imem_addr", imem_addr, 32'h300);
    cyc(); redirect_pc = 32'h400; @(negedge clk);
    chk("b2b2_imem_addr", imem_addr, 32'h400);
    chk("b2b2_if_valid", {31'd0, if_valid}, 32'd0);
    cyc(); redirect_valid = 1'b0; @(negedge clk);
    chk("b2b_if_pc", if_pc, 32'h400);

    cyc(); id_stall = 1'b1; @(negedge clk);      // 0x404 held valid
    chk("pre_arst_if_valid", {31'd0, if_valid}, 32'd1);
    chk("pre_arst_count", fetch_count, 32'd9);
    chk("queue_drained", exp_q.size(), 32'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_imem_stall", {31'd0, imem_stall}, 32'd0);
    chk("arst_if_pc", if_pc, 32'h0);

    cyc(); id_stall = 1'b0;
    push(32'h0, 1'b0); push(32'h4, 1'b0);
    cyc(); rst_n = 1'b1;
    cyc(); @(negedge clk);
    chk("restart_if_pc0", if_pc, 32'h0);
    cyc(); @(negedge clk);
    chk("restart_if_pc1", if_pc, 32'h4);
    cyc(); id_stall = 1'b1; @(negedge clk);
    chk("restart_count", fetch_count, 32'd2);
    chk("final_queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
